bru_pipe: RTL and testbench
===========================

# bru_pipe

Parametrised, pipelined branch/jump functional unit that succeeds the single-slot branch unit in the out-of-order backend. It accepts one issue packet per cycle from the BRU reservation station and resolves conditions and targets over a configurable number of pipeline stages. It compares each outcome against the front-end prediction carried with the op and raises a redirect only on mispredict. Results leave through a single backpressured output slot that feeds the CDB/PRF, ROB completion and fetch redirect.

## Interface
- XLEN_P, default XLEN: datapath width.
- STAGES, default 2, legal range 1..4: pipeline depth, equal to latency from accept to output valid.
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- flush_i  in  1  kills all in-flight ops.
- issue_valid_i  in  1  packet offered.
- issue_ready_o  out  1  packet accepted when both are high.
- issue_pkt_i  in  issue_pkt_t  uses pc, alu_op, imm, imm_used, is_branch, is_jump, rs1_tag, rs2_tag, rd_used, rd_tag, rob_tag.
- pred_taken_i  in  1  front-end predicted direction.
- pred_target_i  in  XLEN_P  front-end predicted target.
- prf_rs1_tag_o / prf_rs2_tag_o  out  PREG_W  equal to issue_pkt_i.rs1_tag / rs2_tag, combinational.
- prf_rs1_data_i / prf_rs2_data_i  in  XLEN_P  same-cycle read data.
- out_ready_i  in  1  downstream accepts the output slot.
- wb_valid_o, wb_tag_o [PREG_W], wb_data_o [XLEN_P]  out  link write.
- cpl_valid_o, cpl_tag_o [ROB_TAG_W], cpl_exc_o [1]  out  ROB completion and misaligned-target flag.
- br_redir_valid_o, br_redir_pc_o [XLEN_P], br_taken_o  out  redirect request and actual direction.

## Operation
- Stage 1 captures the packet, prediction and both operands on accept. The last stage is the output slot (out_v).
- Branch condition on alu_op: 0 BEQ, 1 BNE, 2 BLT (signed), 3 BGE (signed), 4 BLTU, 5 BGEU. Any other value gives not-taken.
- Jump: always taken. imm_used=1 gives target (rs1+imm) with bit 0 cleared (JALR). imm_used=0 gives target pc+imm (JAL).
- Branch target is pc+imm. Fall-through is pc+4. All adds wrap modulo 2^XLEN_P.
- Condition and target are computed from stage-1 registers and carried forward. For STAGES=1 they are computed combinationally from the output slot.
- Mispredict when actual_taken != pred_taken, or when actual_taken and target != pred_target.
- Redirect PC is target if taken, else pc+4.
- Misaligned: taken and target[1:0] != 0. This sets cpl_exc_o and suppresses redirect and wb.
- wb_valid_o = out_v & is_jump & rd_used & !misaligned. wb_data_o = pc+4.
- cpl_valid_o = out_v.
- br_redir_valid_o = out_v & mispredict & !misaligned.
- br_taken_o = out_v & actual_taken.
- Neither is_branch nor is_jump: complete with no wb and no redirect.

## Timing
- Reset: all stage valids are 0. Every output valid, cpl_exc_o and br_taken_o are 0. Tag and data outputs are 0. issue_ready_o is 1.
- Latency is exactly STAGES cycles from the accept edge to out_v, absent stalls. Throughput is 1 op per cycle.
- Stall = out_v & !out_ready_i. A stall freezes every stage.
- issue_ready_o = !stall. This is combinational on out_ready_i, and bubbles still advance only when the pipeline is not stalled.
- Outputs hold stable while stalled. The slot retires on out_v & out_ready_i.
- flush_i has priority over accept and stall. All valids clear on the next edge, an op offered in the same cycle is dropped, and the next cycle's outputs are invalid.
- An async reset mid-stall clears everything immediately.

## Configuration
- BRU_PIPE_STATS_EN defined: adds 32-bit saturating counters stat_branches_o and stat_mispred_o, reset 0. They increment on every retired branch/jump and every retired redirect, respectively; flushed ops are not counted.
- Macro undefined: these ports and counters are absent, and behaviour is otherwise identical.

## Test plan
- STAGES=2, BEQ with rs1=rs2=5, pc=0x100, imm=0x20, pred_taken=0 -> two cycles later: cpl_valid, br_taken=1, redirect valid, redir_pc=0x120.
- BLT with rs1=0xFFFFFFFF, rs2=1, pred_taken=1, pred_target=pc+imm -> taken, no redirect. BLTU with the same operands, pred_taken=1 -> redirect to pc+4.
- JALR with rs1=0x1001, imm=4, rd_used=1, pc=0x200, pred_target=0x1004 -> wb_data=0x204, target 0x1004, no redirect. With rs1=0x1002 -> target 0x1006, cpl_exc=1, no wb, no redirect.
- Back-to-back issue of 4 ops with out_ready_i low for 3 cycles -> issue_ready low during the stall, outputs held, all 4 retire in order, none lost or duplicated.
- flush_i asserted with 2 ops in flight and a new op offered -> no outputs on following cycles; a fresh op issued afterwards completes after STAGES cycles.
- STAGES=1 and STAGES=4 regressions of the above; with BRU_PIPE_STATS_EN defined, counters match the retired and redirect totals.

Source files
------------

// File: rtl/bru_pipe.sv
// Pipelined branch/jump unit: resolves direction/target, flags mispredicts, drives wb/completion/redirect.
// Optional BRU_PIPE_STATS_EN adds saturating retire/redirect counters.
package bru_pipe_pkg;
  parameter int XLEN      = 32;
  parameter int PREG_W    = 6;
  parameter int ROB_TAG_W = 6;

  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic [3:0]           alu_op;
    logic [XLEN-1:0]      imm;
    logic                 imm_used;
    logic                 is_branch;
    logic                 is_jump;
    logic [PREG_W-1:0]    rs1_tag;
    logic [PREG_W-1:0]    rs2_tag;
    logic                 rd_used;
    logic [PREG_W-1:0]    rd_tag;
    logic [ROB_TAG_W-1:0] rob_tag;
  } issue_pkt_t;
endpackage

module bru_pipe
  import bru_pipe_pkg::*;
#(
  parameter int XLEN_P = XLEN,
  parameter int STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  input  logic                 issue_valid_i,
  output logic                 issue_ready_o,
  input  issue_pkt_t           issue_pkt_i,
  input  logic                 pred_taken_i,
  input  logic [XLEN_P-1:0]    pred_target_i,
  output logic [PREG_W-1:0]    prf_rs1_tag_o,
  output logic [PREG_W-1:0]    prf_rs2_tag_o,
  input  logic [XLEN_P-1:0]    prf_rs1_data_i,
  input  logic [XLEN_P-1:0]    prf_rs2_data_i,
  input  logic                 out_ready_i,
  output logic                 wb_valid_o,
  output logic [PREG_W-1:0]    wb_tag_o,
  output logic [XLEN_P-1:0]    wb_data_o,
  output logic                 cpl_valid_o,
  output logic [ROB_TAG_W-1:0] cpl_tag_o,
  output logic                 cpl_exc_o,
  output logic                 br_redir_valid_o,
  output logic [XLEN_P-1:0]    br_redir_pc_o,
  output logic                 br_taken_o
`ifdef BRU_PIPE_STATS_EN
  ,
  output logic [31:0]          stat_branches_o,
  output logic [31:0]          stat_mispred_o
`endif
);

  typedef enum logic [3:0] {
    BR_EQ  = 4'd0,
    BR_NE  = 4'd1,
    BR_LT  = 4'd2,
    BR_GE  = 4'd3,
    BR_LTU = 4'd4,
    BR_GEU = 4'd5
  } br_op_e;

  typedef struct packed {
    logic                 taken;
    logic                 mispred;
    logic                 misal;
    logic                 is_jump;
    logic                 rd_used;
    logic [PREG_W-1:0]    rd_tag;
    logic [ROB_TAG_W-1:0] rob_tag;
    logic [XLEN_P-1:0]    redir_pc;
    logic [XLEN_P-1:0]    pc4;
`ifdef BRU_PIPE_STATS_EN
    logic                 is_ctl;
`endif
  } res_t;

  logic stall;
  logic out_v;
  res_t out_r;
  res_t res_c;

  assign stall         = out_v & ~out_ready_i;
  assign issue_ready_o = ~stall;
  assign prf_rs1_tag_o = issue_pkt_i.rs1_tag;
  assign prf_rs2_tag_o = issue_pkt_i.rs2_tag;

  // Stage 1: raw capture of packet, prediction and operands
  logic                 s1_v;
  logic [XLEN_P-1:0]    s1_pc, s1_imm, s1_a, s1_b, s1_ptgt;
  logic [3:0]           s1_op;
  logic                 s1_imm_used, s1_is_br, s1_is_j, s1_rd_used, s1_pt;
  logic [PREG_W-1:0]    s1_rd_tag;
  logic [ROB_TAG_W-1:0] s1_rob_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v        <= 1'b0;
      s1_pc       <= '0;
      s1_imm      <= '0;
      s1_a        <= '0;
      s1_b        <= '0;
      s1_ptgt     <= '0;
      s1_op       <= '0;
      s1_imm_used <= 1'b0;
      s1_is_br    <= 1'b0;
      s1_is_j     <= 1'b0;
      s1_rd_used  <= 1'b0;
      s1_pt       <= 1'b0;
      s1_rd_tag   <= '0;
      s1_rob_tag  <= '0;
    end else if (flush_i) begin
      s1_v <= 1'b0;
    end else if (!stall) begin
      s1_v <= issue_valid_i;
      if (issue_valid_i) begin
        s1_pc       <= issue_pkt_i.pc;
        s1_imm      <= issue_pkt_i.imm;
        s1_a        <= prf_rs1_data_i;
        s1_b        <= prf_rs2_data_i;
        s1_ptgt     <= pred_target_i;
        s1_op       <= issue_pkt_i.alu_op;
        s1_imm_used <= issue_pkt_i.imm_used;
        s1_is_br    <= issue_pkt_i.is_branch;
        s1_is_j     <= issue_pkt_i.is_jump;
        s1_rd_used  <= issue_pkt_i.rd_used;
        s1_pt       <= pred_taken_i;
        s1_rd_tag   <= issue_pkt_i.rd_tag;
        s1_rob_tag  <= issue_pkt_i.rob_tag;
      end
    end
  end

  logic              cond, is_ctl, jalr;
  logic [XLEN_P-1:0] tgt_sum, tgt;

  always_comb begin
    cond = 1'b0;
    case (br_op_e'(s1_op))
      BR_EQ:   cond = (s1_a == s1_b);
      BR_NE:   cond = (s1_a != s1_b);
      BR_LT:   cond = ($signed(s1_a) <  $signed(s1_b));
      BR_GE:   cond = ($signed(s1_a) >= $signed(s1_b));
      BR_LTU:  cond = (s1_a <  s1_b);
      BR_GEU:  cond = (s1_a >= s1_b);
      default: cond = 1'b0;
    endcase

    jalr    = s1_is_j & s1_imm_used;
    is_ctl  = s1_is_br | s1_is_j;
    tgt_sum = (jalr ? s1_a : s1_pc) + s1_imm;
    tgt     = jalr ? {tgt_sum[XLEN_P-1:1], 1'b0} : tgt_sum;

    res_c          = '0;
    res_c.taken    = s1_is_j | (s1_is_br & cond);
    res_c.pc4      = s1_pc + XLEN_P'(4);
    res_c.redir_pc = res_c.taken ? tgt : res_c.pc4;
    res_c.misal    = res_c.taken & (tgt[1:0] != 2'b00);
    res_c.mispred  = is_ctl & ((res_c.taken != s1_pt) | (res_c.taken & (tgt != s1_ptgt)));
    res_c.is_jump  = s1_is_j;
    res_c.rd_used  = s1_rd_used;
    res_c.rd_tag   = s1_rd_tag;
    res_c.rob_tag  = s1_rob_tag;
`ifdef BRU_PIPE_STATS_EN
    res_c.is_ctl   = is_ctl;
`endif
  end

  // Resolution happens once after stage 1; later stages only carry the result
  if (STAGES == 1) begin : g_comb
    assign out_v = s1_v;
    assign out_r = res_c;
  end else begin : g_pipe
    logic [STAGES-2:0] rv;
    res_t              rq [STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rv <= '0;
        for (int unsigned k = 0; k < STAGES - 1; k++) rq[k] <= '0;
      end else if (flush_i) begin
        rv <= '0;
      end else if (!stall) begin
        rv[0] <= s1_v;
        rq[0] <= res_c;
        for (int unsigned k = 1; k < STAGES - 1; k++) begin
          rv[k] <= rv[k-1];
          rq[k] <= rq[k-1];
        end
      end
    end

    assign out_v = rv[STAGES-2];
    assign out_r = rq[STAGES-2];
  end

  assign cpl_valid_o      = out_v;
  assign cpl_tag_o        = out_v ? out_r.rob_tag : '0;
  assign cpl_exc_o        = out_v & out_r.misal;
  assign wb_valid_o       = out_v & out_r.is_jump & out_r.rd_used & ~out_r.misal;
  assign wb_tag_o         = out_v ? out_r.rd_tag : '0;
  assign wb_data_o        = out_v ? out_r.pc4 : '0;
  assign br_redir_valid_o = out_v & out_r.mispred & ~out_r.misal;
  assign br_redir_pc_o    = out_v ? out_r.redir_pc : '0;
  assign br_taken_o       = out_v & out_r.taken;

`ifdef BRU_PIPE_STATS_EN
  logic retire;
  assign retire = out_v & out_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches_o <= '0;
      stat_mispred_o  <= '0;
    end else begin
      if (retire && out_r.is_ctl && stat_branches_o != '1)
        stat_branches_o <= stat_branches_o + 32'd1;
      if (retire && br_redir_valid_o && stat_mispred_o != '1)
        stat_mispred_o <= stat_mispred_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bru_pipe.sv
// Directed self-checking bench for bru_pipe; override STAGES_TB to cover other depths.
module tb_bru_pipe;
  import bru_pipe_pkg::*;

  parameter int STAGES_TB = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_i = 1'b0;
  logic        issue_valid_i = 1'b0;
  logic        issue_ready_o;
  issue_pkt_t  pkt = '0;
  logic        pred_taken_i = 1'b0;
  logic [31:0] pred_target_i = '0;
  logic [5:0]  prf_rs1_tag_o, prf_rs2_tag_o;
  logic [31:0] prf_rs1_data_i = '0, prf_rs2_data_i = '0;
  logic        out_ready_i = 1'b1;
  logic        wb_valid_o, cpl_valid_o, cpl_exc_o, br_redir_valid_o, br_taken_o;
  logic [5:0]  wb_tag_o, cpl_tag_o;
  logic [31:0] wb_data_o, br_redir_pc_o;
`ifdef BRU_PIPE_STATS_EN
  logic [31:0] stat_branches_o, stat_mispred_o;
`endif

  bru_pipe #(.XLEN_P(32), .STAGES(STAGES_TB)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o), .issue_pkt_i(pkt),
    .pred_taken_i(pred_taken_i), .pred_target_i(pred_target_i),
    .prf_rs1_tag_o(prf_rs1_tag_o), .prf_rs2_tag_o(prf_rs2_tag_o),
    .prf_rs1_data_i(prf_rs1_data_i), .prf_rs2_data_i(prf_rs2_data_i),
    .out_ready_i(out_ready_i),
    .wb_valid_o(wb_valid_o), .wb_tag_o(wb_tag_o), .wb_data_o(wb_data_o),
    .cpl_valid_o(cpl_valid_o), .cpl_tag_o(cpl_tag_o), .cpl_exc_o(cpl_exc_o),
    .br_redir_valid_o(br_redir_valid_o), .br_redir_pc_o(br_redir_pc_o), .br_taken_o(br_taken_o)
`ifdef BRU_PIPE_STATS_EN
    , .stat_branches_o(stat_branches_o), .stat_mispred_o(stat_mispred_o)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_br   = 0;
  int exp_mis  = 0;
  logic [5:0] next_tag = 6'd1;
  logic       mon_en = 1'b0;
  logic [5:0] mon_q[$];

  always @(negedge clk) begin
    #2;
    if (mon_en && cpl_valid_o && out_ready_i) mon_q.push_back(cpl_tag_o);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
  endtask

  task automatic drive_op(input logic [31:0] pc, input logic [3:0] op, input logic [31:0] imm,
                          input logic iu, input logic br, input logic j,
                          input logic [31:0] a, input logic [31:0] b, input logic rdu,
                          input logic [5:0] tag, input logic pt, input logic [31:0] ptgt);
    pkt           = '0;
    pkt.pc        = pc;
    pkt.alu_op    = op;
    pkt.imm       = imm;
    pkt.imm_used  = iu;
    pkt.is_branch = br;
    pkt.is_jump   = j;
    pkt.rs1_tag   = tag;
    pkt.rs2_tag   = ~tag;
    pkt.rd_used   = rdu;
    pkt.rd_tag    = tag;
    pkt.rob_tag   = tag;
    prf_rs1_data_i = a;
    prf_rs2_data_i = b;
    pred_taken_i   = pt;
    pred_target_i  = ptgt;
    issue_valid_i  = 1'b1;
  endtask

  // Issue one op with out_ready high, then check the output slot STAGES_TB cycles later
  task automatic run_vec(input string nm, input logic [31:0] pc, input logic [3:0] op,
                         input logic [31:0] imm, input logic iu, input logic br, input logic j,
                         input logic [31:0] a, input logic [31:0] b, input logic rdu,
                         input logic pt, input logic [31:0] ptgt,
                         input logic e_tk, input logic e_rd, input logic [31:0] e_rpc,
                         input logic e_wb, input logic [31:0] e_wbd, input logic e_exc);
    logic [5:0] tag;
    tag = next_tag;
    next_tag = next_tag + 6'd1;
    drive_op(pc, op, imm, iu, br, j, a, b, rdu, tag, pt, ptgt);
    @(posedge clk); #1;
    issue_valid_i = 1'b0;
    repeat (STAGES_TB - 1) @(posedge clk);
    #1;
    check({nm, "_cpl"},   32'(cpl_valid_o), 32'd1);
    check({nm, "_tag"},   32'(cpl_tag_o), 32'(tag));
    check({nm, "_taken"}, 32'(br_taken_o), 32'(e_tk));
    check({nm, "_redir"}, 32'(br_redir_valid_o), 32'(e_rd));
    if (e_rd) check({nm, "_rpc"}, br_redir_pc_o, e_rpc);
    check({nm, "_wb"},    32'(wb_valid_o), 32'(e_wb));
    if (e_wb) begin
      check({nm, "_wbdata"}, wb_data_o, e_wbd);
      check({nm, "_wbtag"},  32'(wb_tag_o), 32'(tag));
    end
    check({nm, "_exc"},   32'(cpl_exc_o), 32'(e_exc));
    if (br || j) exp_br++;
    if (e_rd) exp_mis++;
  endtask

  initial begin
    logic [5:0] held;
    bit         seen;
    int         g;

    #12;
    check("rst_ready",  32'(issue_ready_o), 32'd1);
    check("rst_cpl",    32'(cpl_valid_o), 32'd0);
    check("rst_wb",     32'(wb_valid_o), 32'd0);
    check("rst_redir",  32'(br_redir_valid_o), 32'd0);
    check("rst_taken",  32'(br_taken_o), 32'd0);
    check("rst_exc",    32'(cpl_exc_o), 32'd0);
    check("rst_wbdata", wb_data_o, 32'd0);
    check("rst_rpc",    br_redir_pc_o, 32'd0);
    check("rst_tags",   32'({wb_tag_o, cpl_tag_o}), 32'd0);
`ifdef BRU_PIPE_STATS_EN
    check("rst_stat_br",  stat_branches_o, 32'd0);
    check("rst_stat_mis", stat_mispred_o, 32'd0);
`endif
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    pkt.rs1_tag = 6'd3; pkt.rs2_tag = 6'd9; #1;
    check("prf_tag1", 32'(prf_rs1_tag_o), 32'd3);
    check("prf_tag2", 32'(prf_rs2_tag_o), 32'd9);

    //      name      pc            op    imm          iu    br    j     rs1           rs2       rdu   pt    ptgt           tk    rd    rpc           wb    wbdata        exc
    run_vec("beq",    32'h100,      4'd0, 32'h20,      1'b0, 1'b1, 1'b0, 32'd5,        32'd5,    1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h120,      1'b0, 32'h0,        1'b0);
    run_vec("blt",    32'h300,      4'd2, 32'h40,      1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'd1,    1'b0, 1'b1, 32'h340,       1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0);
    run_vec("bltu",   32'h300,      4'd4, 32'h40,      1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'd1,    1'b0, 1'b1, 32'h340,       1'b0, 1'b1, 32'h304,      1'b0, 32'h0,        1'b0);
    run_vec("jalr",   32'h200,      4'd0, 32'h4,       1'b1, 1'b0, 1'b1, 32'h1001,     32'd0,    1'b1, 1'b1, 32'h1004,      1'b1, 1'b0, 32'h0,        1'b1, 32'h204,      1'b0);
    run_vec("jalrmis",32'h200,      4'd0, 32'h4,       1'b1, 1'b0, 1'b1, 32'h1002,     32'd0,    1'b1, 1'b1, 32'h1004,      1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1);
    run_vec("jal",    32'h400,      4'd0, 32'h100,     1'b0, 1'b0, 1'b1, 32'd0,        32'd0,    1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h500,      1'b1, 32'h404,      1'b0);
    run_vec("bne",    32'h500,      4'd1, 32'h8,       1'b0, 1'b1, 1'b0, 32'd7,        32'd7,    1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0);
    run_vec("bge",    32'h600,      4'd3, 32'h10,      1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'd1,    1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0);
    run_vec("bgeu",   32'h600,      4'd5, 32'h10,      1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'd1,    1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h610,      1'b0, 32'h0,        1'b0);
    run_vec("badop",  32'h700,      4'd7, 32'h10,      1'b0, 1'b1, 1'b0, 32'd0,        32'd0,    1'b0, 1'b1, 32'h710,       1'b0, 1'b1, 32'h704,      1'b0, 32'h0,        1'b0);
    run_vec("wrap",   32'hFFFFFFF0, 4'd0, 32'h20,      1'b0, 1'b1, 1'b0, 32'd1,        32'd1,    1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h10,       1'b0, 32'h0,        1'b0);
    run_vec("badtgt", 32'h800,      4'd0, 32'h10,      1'b0, 1'b1, 1'b0, 32'd2,        32'd2,    1'b0, 1'b1, 32'h998,       1'b1, 1'b1, 32'h810,      1'b0, 32'h0,        1'b0);
    run_vec("nonctl", 32'h900,      4'd0, 32'h10,      1'b0, 1'b0, 1'b0, 32'd2,        32'd2,    1'b1, 1'b1, 32'h0,         1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0);
    run_vec("brmis",  32'h100,      4'd0, 32'h22,      1'b0, 1'b1, 1'b0, 32'd3,        32'd3,    1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1);

    @(posedge clk); #1;
    check("idle_cpl", 32'(cpl_valid_o), 32'd0);

    // Back-to-back issue with a 3-cycle output stall
    mon_q.delete();
    mon_en = 1'b1;
    out_ready_i = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          drive_op(32'h1000 + 32'(i * 4), 4'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0,
                   1'b0, 6'(10 + i), 1'b0, 32'h0);
          g = 0;
          @(negedge clk); #2;
          while (!issue_ready_o && g < 50) begin @(negedge clk); #2; g++; end
          @(posedge clk); #1;
        end
        issue_valid_i = 1'b0;
      end
      begin
        int w;
        w = 0;
        @(negedge clk);
        while (!cpl_valid_o && w < 50) begin @(negedge clk); w++; end
        check("stall_seen", 32'(cpl_valid_o), 32'd1);
        held = cpl_tag_o;
        check("stall_first", 32'(held), 32'd10);
        for (int c = 0; c < 3; c++) begin
          check($sformatf("stall%0d_ready", c), 32'(issue_ready_o), 32'd0);
          check($sformatf("stall%0d_hold", c), 32'(cpl_tag_o), 32'(held));
          if (c < 2) @(negedge clk);
        end
        out_ready_i = 1'b1;
        #1;
        check("stall_release_ready", 32'(issue_ready_o), 32'd1);
      end
    join
    repeat (STAGES_TB + 6) @(posedge clk);
    #4;
    mon_en = 1'b0;
    check("stall_count", 32'(mon_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < mon_q.size(); i++)
      check($sformatf("stall_order%0d", i), 32'(mon_q[i]), 32'(10 + i));

    // Flush with ops in flight and a same-cycle offer
    @(posedge clk); #1;
    drive_op(32'h2000, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 6'd20, 1'b0, 32'h0);
    @(posedge clk); #1;
    drive_op(32'h2004, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 6'd21, 1'b0, 32'h0);
    @(posedge clk); #1;
    drive_op(32'h2008, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 6'd22, 1'b0, 32'h0);
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    issue_valid_i = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < STAGES_TB + 2; c++) begin
      if (cpl_valid_o || wb_valid_o || br_redir_valid_o) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("flush_quiet", 32'(seen), 32'd0);
    drive_op(32'h3000, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 6'd23, 1'b0, 32'h0);
    @(posedge clk); #1;
    issue_valid_i = 1'b0;
    repeat (STAGES_TB - 1) @(posedge clk);
    #1;
    check("flush_fresh_cpl", 32'(cpl_valid_o), 32'd1);
    check("flush_fresh_tag", 32'(cpl_tag_o), 32'd23);
    @(posedge clk); #1;

`ifdef BRU_PIPE_STATS_EN
    check("stat_branches", stat_branches_o, 32'(exp_br));
    check("stat_mispred",  stat_mispred_o, 32'(exp_mis));
`endif

    // Asynchronous reset while stalled
    out_ready_i = 1'b0;
    drive_op(32'h4000, 4'd0, 32'h20, 1'b0, 1'b1, 1'b0, 32'd1, 32'd1, 1'b0, 6'd30, 1'b0, 32'h0);
    @(posedge clk); #1;
    issue_valid_i = 1'b0;
    g = 0;
    while (!cpl_valid_o && g < 20) begin @(posedge clk); #1; g++; end
    check("rststall_held", 32'(cpl_valid_o), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rststall_cpl",   32'(cpl_valid_o), 32'd0);
    check("rststall_redir", 32'(br_redir_valid_o), 32'd0);
    check("rststall_ready", 32'(issue_ready_o), 32'd1);
    check("rststall_rpc",   br_redir_pc_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready_i = 1'b1;
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
